// File: rtl/taint_pkg.sv
// Shared widths, taint bit positions and types for the taint-propagation stage.
package taint_pkg;
  localparam int HALF_W       = 32;
  localparam int WORD_W       = 2 * HALF_W;
  localparam int TAINT_HI_BIT = 2 * HALF_W - 1;
  localparam int TAINT_LO_BIT = HALF_W - 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [1:0]        taint_src_t;
endpackage

// File: rtl/taint_merge.sv
// Combinational taint merge: if either half's MSB is set, set both; all other bits pass through.
module taint_merge
  import taint_pkg::*;
#(
  parameter int HALF_W = taint_pkg::HALF_W
) (
  input  logic [2*HALF_W-1:0] i,
  output logic [2*HALF_W-1:0] next_o,
  output logic                t
);

  always_comb begin
    t                    = i[2*HALF_W-1] | i[HALF_W-1];
    next_o               = i;
    next_o[2*HALF_W-1]   = t;
    next_o[HALF_W-1]     = t;
  end

endmodule

// File: rtl/taint_propagate.sv
// Registered taint-propagation stage (1-cycle latency, no backpressure).
// Optional sticky flag and saturating taint counter enabled by defining TAINT_STICKY_EN.
module taint_propagate
  import taint_pkg::*;
#(
  parameter int HALF_W = taint_pkg::HALF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [2*HALF_W-1:0] i,
`ifdef TAINT_STICKY_EN
  input  logic                sticky_clr,
  output logic                taint_sticky,
  output logic [15:0]         taint_count,
`endif
  output logic                out_valid,
  output logic [2*HALF_W-1:0] o,
  output logic                taint_any,
  output logic [1:0]          taint_src
);

  logic [2*HALF_W-1:0] merged;
  logic                t;

  taint_merge #(.HALF_W(HALF_W)) u_merge (
    .i      (i),
    .next_o (merged),
    .t      (t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o         <= '0;
      out_valid <= 1'b0;
      taint_any <= 1'b0;
      taint_src <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o         <= merged;
        taint_any <= t;
        taint_src <= {i[2*HALF_W-1], i[HALF_W-1]};
      end
    end
  end

`ifdef TAINT_STICKY_EN
  // A tainted word accepted in the same cycle as a clear still registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      taint_sticky <= 1'b0;
      taint_count  <= '0;
    end else if (in_valid && t) begin
      taint_sticky <= 1'b1;
      if (sticky_clr)
        taint_count <= 16'd1;
      else if (taint_count != 16'hFFFF)
        taint_count <= taint_count + 16'd1;
    end else if (sticky_clr) begin
      taint_sticky <= 1'b0;
      taint_count  <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_taint_propagate.sv
// Self-checking bench for taint_propagate: directed test-plan vectors then randomized traffic
// against a behavioural model. Define TAINT_STICKY_EN to also exercise the sticky/count outputs.
module tb_taint_propagate;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] i;
  logic        out_valid;
  logic [63:0] o;
  logic        taint_any;
  logic [1:0]  taint_src;
`ifdef TAINT_STICKY_EN
  logic        sticky_clr;
  logic        taint_sticky;
  logic [15:0] taint_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  // behavioural model state
  logic [63:0] m_o;
  logic        m_valid;
  logic        m_any;
  logic [1:0]  m_src;
  logic        m_sticky;
  int          m_count;

  always #5 clk = ~clk;

  taint_propagate dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .i            (i),
`ifdef TAINT_STICKY_EN
    .sticky_clr   (sticky_clr),
    .taint_sticky (taint_sticky),
    .taint_count  (taint_count),
`endif
    .out_valid    (out_valid),
    .o            (o),
    .taint_any    (taint_any),
    .taint_src    (taint_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, update model after the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic r, input logic v, input logic [63:0] d,
                      input logic clr);
    logic tnt;
    rst      = r;
    in_valid = v;
    i        = d;
`ifdef TAINT_STICKY_EN
    sticky_clr = clr;
`endif
    @(posedge clk);
    tnt = d[63] | d[31];
    if (r) begin
      m_o = '0; m_valid = 0; m_any = 0; m_src = 2'b00; m_sticky = 0; m_count = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_o   = tnt ? (d | 64'h8000_0000_8000_0000) : d;
        m_any = tnt;
        m_src = {d[63], d[31]};
      end
      if (clr) begin
        m_sticky = 0;
        m_count  = 0;
      end
      if (v && tnt) begin
        m_sticky = 1;
        if (m_count < 65535) m_count = m_count + 1;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".o"},         o,              m_o);
    chk({tag, ".taint_any"}, 64'(taint_any), 64'(m_any));
    chk({tag, ".taint_src"}, 64'(taint_src), 64'(m_src));
`ifdef TAINT_STICKY_EN
    chk({tag, ".taint_sticky"}, 64'(taint_sticky), 64'(m_sticky));
    chk({tag, ".taint_count"},  64'(taint_count),  64'(m_count));
`endif
    $display("%s: rst=%0b v=%0b i=%h -> out_valid=%0b o=%h any=%0b src=%b",
             tag, r, v, d, out_valid, o, taint_any, taint_src);
  endtask

  logic [63:0] dir_vec [11];
  logic [63:0] dir_exp [11];

  initial begin
    logic [63:0] d;
    rst = 1'b1; in_valid = 1'b0; i = '0;
`ifdef TAINT_STICKY_EN
    sticky_clr = 1'b0;
`endif
    m_o = '0; m_valid = 0; m_any = 0; m_src = 0; m_sticky = 0; m_count = 0;

    step("reset0", 1'b1, 1'b0, 64'h0, 1'b0);
    step("reset1", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Test-plan vectors with hand-written expected outputs.
    dir_vec[0]  = 64'h70042331700FACE0; dir_exp[0]  = 64'h70042331700FACE0;
    dir_vec[1]  = 64'h700000000CAEF120; dir_exp[1]  = 64'h700000000CAEF120;
    dir_vec[2]  = 64'h0;                dir_exp[2]  = 64'h0;
    dir_vec[3]  = 64'hE000000070000000; dir_exp[3]  = 64'hE0000000F0000000;
    dir_vec[4]  = 64'h8000000000000000; dir_exp[4]  = 64'h8000000080000000;
    dir_vec[5]  = 64'h70000000FACE0000; dir_exp[5]  = 64'hF0000000FACE0000;
    dir_vec[6]  = 64'h0000000080000000; dir_exp[6]  = 64'h8000000080000000;
    dir_vec[7]  = 64'hF0042331F00FACE0; dir_exp[7]  = 64'hF0042331F00FACE0;
    dir_vec[8]  = 64'hF00000008CAEF120; dir_exp[8]  = 64'hF00000008CAEF120;
    dir_vec[9]  = 64'h7FFFFFFF7FFFFFFF; dir_exp[9]  = 64'h7FFFFFFF7FFFFFFF;
    dir_vec[10] = 64'hFFFFFFFFFFFFFFFF; dir_exp[10] = 64'hFFFFFFFFFFFFFFFF;
    for (int k = 0; k < 11; k++) begin
      step($sformatf("dir%0d", k), 1'b0, 1'b1, dir_vec[k], 1'b0);
      chk($sformatf("dir%0d.table", k), o, dir_exp[k]);
    end

    // Hold with in_valid low: o keeps the last word.
    step("dirA", 1'b0, 1'b1, 64'h70000000FACE0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("idle%0d", k), 1'b0, 1'b0, 64'h0000000080000000, 1'b0);
      chk($sformatf("idle%0d.hold", k), o, 64'hF0000000FACE0000);
    end

    // Reset wins over a valid tainted input.
    step("rst_vs_valid", 1'b1, 1'b1, 64'h8000000000000000, 1'b0);
    chk("rst_vs_valid.zero", o, 64'h0);
    chk("rst_vs_valid.nv", 64'(out_valid), 64'h0);

`ifdef TAINT_STICKY_EN
    step("stk_t0", 1'b0, 1'b1, 64'h8000000000000000, 1'b0);
    step("stk_c0", 1'b0, 1'b1, 64'h1234567812345678, 1'b0);
    step("stk_t1", 1'b0, 1'b1, 64'h0000000080000000, 1'b0);
    step("stk_c1", 1'b0, 1'b1, 64'h0, 1'b0);
    step("stk_t2", 1'b0, 1'b1, 64'hF0000000F0000000, 1'b0);
    chk("stk.sticky3", 64'(taint_sticky), 64'h1);
    chk("stk.count3",  64'(taint_count),  64'd3);
    step("stk_clr", 1'b0, 1'b1, 64'h0, 1'b1);
    chk("stk_clr.sticky", 64'(taint_sticky), 64'h0);
    chk("stk_clr.count",  64'(taint_count),  64'h0);
    step("stk_clr_set", 1'b0, 1'b1, 64'h8000000000000000, 1'b1);
    chk("stk_clr_set.sticky", 64'(taint_sticky), 64'h1);
`endif

    // Randomized traffic: biased taint bits, occasional idle, reset and clear.
    for (int k = 0; k < 300; k++) begin
      d = {$urandom, $urandom};
      d[63] = ($urandom_range(0, 3) == 0);
      d[31] = ($urandom_range(0, 3) == 0);
      step($sformatf("rnd%0d", k), ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           d, ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/taint_propagate.md
Name: taint_propagate

Overview:
- Registered taint-propagation stage for a 64-bit word made of two 32-bit halves.
- The MSB of each half is that half's taint bit: bit 63 for the high half, bit 31 for the low half.
- If either taint bit is set, the stage sets both taint bits in the output word; all other bits pass through unchanged.
- Sits between the datapath source and consumers that check taint per half, with one cycle of latency.

Parameters:
- HALF_W, 32, width of each half; the data word is 2*HALF_W bits and the taint bits are at positions 2*HALF_W-1 and HALF_W-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word is valid this cycle.
- i  in  2*HALF_W  input data word.
- out_valid  out  1  o holds a newly propagated word.
- o  out  2*HALF_W  propagated data word, registered.
- taint_any  out  1  registered: o carries taint (equals o[2*HALF_W-1]).
- taint_src  out  2  registered: {i[63], i[31]} of the captured word, showing which half sourced the taint.

Behaviour:
- Reset is synchronous and active-high; there is one clock, clk. While rst=1 on a clock edge: o=0, out_valid=0, taint_any=0, taint_src=0.
- Merge function: t = i[63] | i[31].
  - next_o = i with bit 63 = t and bit 31 = t.
  - All other bits copied unchanged.
- The merge is idempotent: input with both taint bits set, or neither set, passes through unchanged.
- Latency is 1 cycle. On the clk edge with in_valid=1:
  - o <= next_o
  - taint_src <= {i[63], i[31]}
  - taint_any <= t
  - out_valid <= 1
- On the clk edge with in_valid=0: out_valid <= 0; o, taint_any and taint_src hold their previous values.
- Back-to-back valid inputs produce back-to-back outputs. There is no backpressure and no ready signal.
- rst asserted together with in_valid: reset wins and the input is dropped.
- Inputs with X on non-taint bits propagate unchanged; no checking is done.

Optional Feature:
- Macro TAINT_STICKY_EN.
- When defined, add the following:
  - Input sticky_clr (1 bit).
  - Output taint_sticky (1 bit): set on any accepted word with t=1; cleared by rst or by sticky_clr.
  - If set and clear occur in the same cycle, set wins.
  - Output taint_count (16 bits): increments on each accepted tainted word, saturates at 16'hFFFF, and is cleared by rst or sticky_clr.
- When not defined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Package taint_pkg holds:
  - HALF_W default
  - localparams TAINT_HI_BIT=63 and TAINT_LO_BIT=31 (derived from HALF_W)
  - typedef word_t for the 2*HALF_W-bit logic vector
  - typedef taint_src_t for the 2-bit source vector
- One combinational sub-module, taint_merge (i -> next_o, t), is instantiated inside taint_propagate. It is also reusable wherever unregistered propagation is needed.

Test Plan:
- No taint: 64'h70042331700FACE0, 64'h700000000CAEF120 and 64'h0 each return unchanged one cycle later; out_valid=1, taint_any=0, taint_src=2'b00.
- High-half taint: 64'hE000000070000000 -> 64'hE0000000F0000000; 64'h8000000000000000 -> 64'h8000000080000000; taint_src=2'b10, taint_any=1.
- Low-half taint: 64'h70000000FACE0000 -> 64'hF0000000FACE0000; 64'h0000000080000000 -> 64'h8000000080000000; taint_src=2'b01.
- Both halves tainted: 64'hF0042331F00FACE0 and 64'hF00000008CAEF120 pass through unchanged; taint_src=2'b11.
- Valid and reset:
  - in_valid=0 for 3 cycles: out_valid=0, o holds its last value.
  - rst=1 together with in_valid=1 and i=64'h8000000000000000: next cycle o=0, out_valid=0.
- TAINT_STICKY_EN:
  - Feed 3 tainted words and 2 clean words: taint_sticky=1, taint_count=3.
  - sticky_clr with no taint in the same cycle: both read 0.
  - sticky_clr in the same cycle as a tainted word: taint_sticky=1.
